// File: rtl/bpu_pkg.sv
// bpu_pkg: shared definitions for the branch prediction unit.
//   - default table geometry (index and tag widths)
//   - 2-bit saturating counter type, its encodings and reset value
//   - BTB entry layout
//   - saturating counter next-state helper
package bpu_pkg;

    localparam int unsigned BPU_IDX_W = 6;
    localparam int unsigned BPU_TAG_W = 8;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t CTR_RESET = CTR_WNT;

    // Layout of one BTB word as stored in the table: {valid, tag, target}.
    typedef struct packed {
        logic                 valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    // Counter moves one step toward the resolved outcome and sticks at 00 / 11.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CTR_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_if.sv
// bpu_if: fetch-side and training-side signals of the branch prediction unit.
//   master : IFU / IDU side (drives lookup requests, accepts predictions,
//            flushes, sends resolved branch outcomes)
//   slave  : the bpu itself
//   req_valid/req_ready/req_pc        lookup request handshake
//   pred_valid/pred_ready/pred_*      prediction handshake and payload
//   flush                             drop pending prediction
//   upd_valid/upd_pc/upd_taken/upd_target  resolved conditional branch
interface bpu_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;

    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        flush;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output req_valid, req_pc, pred_ready, flush,
               upd_valid, upd_pc, upd_taken, upd_target,
        input  req_ready, pred_valid, pred_pc, pred_taken, pred_target
    );

    modport slave (
        input  req_valid, req_pc, pred_ready, flush,
               upd_valid, upd_pc, upd_taken, upd_target,
        output req_ready, pred_valid, pred_pc, pred_taken, pred_target
    );

endinterface

// File: rtl/bpu_table.sv
// bpu_table: 2^IDX_W-entry register array of W-bit words.
//   clock, reset : clock and synchronous active-high reset (all entries
//                  return to RESET_VAL)
//   raddr/rdata  : asynchronous read port
//   we/waddr/wdata : write port, written at the clock edge
//   wq           : current contents at waddr, so the owner can do a
//                  read-modify-write through the write port
// A read to the address being written in the same cycle returns the old
// contents; the new value is visible from the next cycle.
module bpu_table #(
    parameter int unsigned W         = 2,
    parameter int unsigned IDX_W     = 6,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] raddr,
    output logic [W-1:0]     rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     wq
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[raddr];
    assign wq    = mem[waddr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/bpu.sv
// bpu: branch prediction unit (direct-mapped BHT of 2-bit counters plus a
// tagged BTB). Lookups answer one cycle after the request fires; training
// comes from resolved conditional branches.
//   clock, reset : clock, synchronous active-high reset
//   bus          : bpu_if.slave (lookup request, prediction output, flush,
//                  update path)
// Optional feature: define BPU_GSHARE_EN to XOR a non-speculative global
// history register into the BHT index (BTB indexing is unaffected).
module bpu
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W = BPU_IDX_W,
    parameter int unsigned TAG_W = BPU_TAG_W
) (
    input  logic  clock,
    input  logic  reset,
    bpu_if.slave  bus
);

    localparam int unsigned BTB_W = 1 + TAG_W + 32;

    logic [IDX_W-1:0] req_idx, upd_idx;
    logic [TAG_W-1:0] req_tag, upd_tag;
    logic [IDX_W-1:0] bht_ridx, bht_widx;

    logic             req_fire;
    ctr_t             bht_rd, bht_wq;
    logic [BTB_W-1:0] btb_rd, btb_wq_unused;
    logic             lk_hit, lk_taken;
    logic [31:0]      lk_target;

    logic             pred_valid_p1;
    logic [31:0]      pred_pc_p1;
    logic             pred_taken_p1;
    logic [31:0]      pred_target_p1;

    assign req_idx = bus.req_pc[IDX_W+1:2];
    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign req_tag = bus.req_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Both lookup and update hash with the history as it stands before this
    // edge's shift.
    assign bht_ridx = req_idx ^ ghr;
    assign bht_widx = upd_idx ^ ghr;

    always_ff @(posedge clock) begin
        if (reset) begin
            ghr <= '0;
        end else if (bus.upd_valid) begin
            ghr <= {ghr[IDX_W-2:0], bus.upd_taken};
        end
    end
`else
    assign bht_ridx = req_idx;
    assign bht_widx = upd_idx;
`endif

    bpu_table #(
        .W         (2),
        .IDX_W     (IDX_W),
        .RESET_VAL (CTR_RESET)
    ) u_bht (
        .clock (clock),
        .reset (reset),
        .raddr (bht_ridx),
        .rdata (bht_rd),
        .we    (bus.upd_valid),
        .waddr (bht_widx),
        .wdata (ctr_next(bht_wq, bus.upd_taken)),
        .wq    (bht_wq)
    );

    // Not-taken outcomes leave the BTB alone so a learned target survives
    // while the counter cools down.
    bpu_table #(
        .W         (BTB_W),
        .IDX_W     (IDX_W),
        .RESET_VAL ('0)
    ) u_btb (
        .clock (clock),
        .reset (reset),
        .raddr (req_idx),
        .rdata (btb_rd),
        .we    (bus.upd_valid & bus.upd_taken),
        .waddr (upd_idx),
        .wdata ({1'b1, upd_tag, bus.upd_target}),
        .wq    (btb_wq_unused)
    );

    assign bus.req_ready = ~pred_valid_p1 | bus.pred_ready;
    assign req_fire      = bus.req_valid & bus.req_ready;

    assign lk_hit    = btb_rd[BTB_W-1] & (btb_rd[TAG_W+31:32] == req_tag);
    assign lk_taken  = lk_hit & bht_rd[1];
    assign lk_target = lk_taken ? btb_rd[31:0] : bus.req_pc + 32'd4;

    // ---- stage p1: prediction output register ----
    // Flush wins over a same-cycle fire; a fire alongside pred_ready
    // replaces the held prediction without a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_valid_p1  <= 1'b0;
            pred_pc_p1     <= '0;
            pred_taken_p1  <= 1'b0;
            pred_target_p1 <= '0;
        end else if (bus.flush) begin
            pred_valid_p1 <= 1'b0;
        end else if (req_fire) begin
            pred_valid_p1  <= 1'b1;
            pred_pc_p1     <= bus.req_pc;
            pred_taken_p1  <= lk_taken;
            pred_target_p1 <= lk_target;
        end else if (bus.pred_ready) begin
            pred_valid_p1 <= 1'b0;
        end
    end

    assign bus.pred_valid  = pred_valid_p1;
    assign bus.pred_pc     = pred_pc_p1;
    assign bus.pred_taken  = pred_taken_p1;
    assign bus.pred_target = pred_target_p1;

endmodule
